// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the
// IF/ID pipeline register. Handles sequential fetch, branch redirect from ID,
// flush redirect from exception/CSR logic and per-stage stalls.
// Optional static JAL prediction is enabled by defining IF_STATIC_PRED_EN.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic [31:0] pc,
    output logic        ce,
    input  logic [31:0] inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_pred
);

    localparam logic [6:0] OpcJal = 7'b1101111;

    logic [31:0] pc_q, pc_d;
    logic        ce_q;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        id_pred_q, id_pred_d;

    // Predecode of the word currently returned by the ROM.
    logic        pred_hit;
    logic [31:0] pred_target;

`ifdef IF_STATIC_PRED_EN
    logic [31:0] jal_imm;
    assign jal_imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign pred_hit    = (inst[6:0] == OpcJal);
    assign pred_target = pc_q + jal_imm;
`else
    logic unused_opc;
    assign unused_opc  = ^OpcJal;
    assign pred_hit    = 1'b0;
    assign pred_target = 32'h0;
`endif

    // Next PC: flush > accepted branch > stall > prediction > sequential.
    always_comb begin
        pc_d = pc_q;
        if (ce_q) begin
            if (flush) begin
                pc_d = flush_target;
            end else if (branch_flag && !stall_id) begin
                pc_d = branch_target;
            end else if (stall_if) begin
                pc_d = pc_q;
            end else if (pred_hit) begin
                pc_d = pred_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // PC and chip-enable registers; ce rises on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= 1'b1;
        end
    end

    // IF/ID next state: flush > ID stall (hold) > branch kill > IF stall > idle > load.
    always_comb begin
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        id_pred_d  = id_pred_q;
        if (flush || (!stall_id && (branch_flag || stall_if || !ce_q))) begin
            id_pc_d    = 32'h0;
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            id_pred_d  = 1'b0;
        end else if (!stall_id) begin
            id_pc_d    = pc_q;
            id_inst_d  = inst;
            id_valid_d = 1'b1;
            id_pred_d  = pred_hit;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            id_pred_q  <= 1'b0;
        end else begin
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            id_pred_q  <= id_pred_d;
        end
    end

    assign pc       = pc_q;
    assign ce       = ce_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
    assign id_pred  = id_pred_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage. Expected IF/ID contents are queued when
// each cycle's stimulus is driven and compared after the following rising edge.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int KFetch  = 0;
    localparam int KBubble = 1;
    localparam int KHold   = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        pred;
    } id_entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if, stall_id, branch_flag, flush;
    logic [31:0] branch_target, flush_target;
    logic [31:0] pc, inst, id_pc, id_inst;
    logic        ce, id_valid, id_pred;

    int n_checks = 0;
    int n_errors = 0;

    id_entry_t   sb_q[$];
    id_entry_t   last_id;
    logic [31:0] cur_pc;

    if_fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .flush        (flush),
        .flush_target (flush_target),
        .pc           (pc),
        .ce           (ce),
        .inst         (inst),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_valid     (id_valid),
        .id_pred      (id_pred)
    );

    always #5 clk = ~clk;

    // ROM contents: a few fixed words, otherwise a non-JAL pattern derived from the address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0010_0093;
            32'h0000_0004: return 32'h0020_0113;
            32'h0000_0020: return 32'h0100_006F;
            default:       return {a[26:0], 5'b0} | 32'h0000_0013;
        endcase
    endfunction

    assign inst = rom(pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, queue expected IF/ID, then compare after the edge.
    task automatic step(input logic r, input logic fl, input logic [31:0] flt,
                        input logic br, input logic [31:0] brt,
                        input logic sif, input logic sid,
                        input logic [31:0] exp_pc, input int kind, input logic exp_pred);
        id_entry_t e;
        id_entry_t got;
        rst = r; flush = fl; flush_target = flt;
        branch_flag = br; branch_target = brt;
        stall_if = sif; stall_id = sid;
        if (kind == KFetch) begin
            e.pc = cur_pc; e.inst = rom(cur_pc); e.valid = 1'b1; e.pred = exp_pred;
        end else if (kind == KHold) begin
            e = last_id;
        end else begin
            e.pc = 32'h0; e.inst = NOP; e.valid = 1'b0; e.pred = 1'b0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check("pc", pc, exp_pc);
        check("ce", {31'b0, ce}, {31'b0, ~r});
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check("id_pc", id_pc, got.pc);
            check("id_inst", id_inst, got.inst);
            check("id_valid", {31'b0, id_valid}, {31'b0, got.valid});
            check("id_pred", {31'b0, id_pred}, {31'b0, got.pred});
            last_id = got;
        end
        cur_pc = exp_pc;
    endtask

    task automatic run(input logic [31:0] exp_pc, input int kind);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, exp_pc, kind, 1'b0);
    endtask

    task automatic jump(input logic [31:0] tgt);
        step(1'b0, 1'b0, 32'h0, 1'b1, tgt, 1'b0, 1'b0, tgt, KBubble, 1'b0);
    endtask

    initial begin
        cur_pc = 32'h0;
        last_id.pc = 32'h0; last_id.inst = NOP; last_id.valid = 1'b0; last_id.pred = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, KBubble, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, KBubble, 1'b0);

        // Release: ce rises with pc held, then two sequential fetches
        run(32'h0, KBubble);
        run(32'h4, KFetch);
        run(32'h8, KFetch);

        // IF stall at 0x8: two bubbles, pc holds
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, KBubble, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, KBubble, 1'b0);
        run(32'hC, KFetch);
        // IF and ID stall: IF/ID holds the instruction from 0x8
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, KHold, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, KHold, 1'b0);
        run(32'h10, KFetch);

        // Branch at 0x10 to 0x40: one bubble, target valid two edges later
        jump(32'h40);
        run(32'h44, KFetch);

        // Branch ignored while ID is stalled; pc advances sequentially, IF/ID holds
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h48, KHold, 1'b0);
        // Branch beats IF stall
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h200, KBubble, 1'b0);
        run(32'h204, KFetch);

        // Flush beats branch
        step(1'b0, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 1'b0, 32'h100, KBubble, 1'b0);
        run(32'h104, KFetch);
        // Flush beats both stalls
        step(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, KBubble, 1'b0);
        run(32'h304, KFetch);

        // Reset during a stall
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, KBubble, 1'b0);
        run(32'h0, KBubble);
        run(32'h4, KFetch);

        // PC wrap
        jump(32'hFFFF_FFFC);
        run(32'h0, KFetch);

        // Unaligned target passes through
        jump(32'h42);
        run(32'h46, KFetch);

        // JAL at 0x20
        jump(32'h20);
`ifdef IF_STATIC_PRED_EN
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h30, KFetch, 1'b1);
        run(32'h34, KFetch);
`else
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h24, KFetch, 1'b0);
        run(32'h28, KFetch);
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
